// File: rtl/param_pipe_adder.sv
// Pipelined N-bit adder/subtractor: one C-bit slice per stage, carries registered
// between stages, global stall flow control with valid/ready on both sides.
module param_pipe_adder #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int C = N / STAGES;

    if (N < 2 || N > 32 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_params
        $error("param_pipe_adder: illegal N/STAGES combination");
    end

    function automatic logic signed_ovf(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    logic en;
    logic ovf_p;

    assign en       = !out_valid || out_ready;
    assign in_ready = en && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic         v_i;
        logic         c_i;
        logic [N-1:0] a_i;
        logic [N-1:0] bx_i;
        logic [N-1:0] s_i;
        logic [C:0]   slice;
        logic [N-1:0] s_nxt;
        logic         vld_p;
        logic         c_p;
        logic [N-1:0] a_p;
        logic [N-1:0] bx_p;
        logic [N-1:0] s_p;

        if (k == 0) begin : g_head
            assign v_i  = in_valid;
            assign a_i  = a;
            assign bx_i = b ^ {N{sub}};
            assign c_i  = cin ^ sub;
            assign s_i  = '0;
        end else begin : g_link
            assign v_i  = g_stage[k-1].vld_p;
            assign a_i  = g_stage[k-1].a_p;
            assign bx_i = g_stage[k-1].bx_p;
            assign c_i  = g_stage[k-1].c_p;
            assign s_i  = g_stage[k-1].s_p;
        end

        assign slice = {1'b0, a_i[k*C +: C]} + {1'b0, bx_i[k*C +: C]} + {{C{1'b0}}, c_i};

        always_comb begin
            s_nxt           = s_i;
            s_nxt[k*C +: C] = slice[C-1:0];
        end

        // ---- stage k register boundary ----
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p <= 1'b0;
            end else if (en) begin
                vld_p <= v_i;
            end
        end

        // Only the final stage drives ports, so only its data is cleared on reset.
        always_ff @(posedge clk) begin
            if (rst && k == STAGES - 1) begin
                s_p <= '0;
                c_p <= 1'b0;
            end else if (en) begin
                s_p <= s_nxt;
                c_p <= slice[C];
            end
        end

        always_ff @(posedge clk) begin
            if (en) begin
                a_p  <= a_i;
                bx_p <= bx_i;
            end
        end
    end

    // ---- output register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_p <= 1'b0;
        end else if (en) begin
            ovf_p <= signed_ovf(g_stage[STAGES-1].a_i[N-1], g_stage[STAGES-1].bx_i[N-1],
                                g_stage[STAGES-1].s_nxt[N-1]);
        end
    end

    // Operand copies leaving the last stage have no consumer.
    logic unused_ops;
    assign unused_ops = ^{g_stage[STAGES-1].a_p, g_stage[STAGES-1].bx_p};

    assign out_valid = g_stage[STAGES-1].vld_p;
    assign sum       = g_stage[STAGES-1].s_p;
    assign cout      = g_stage[STAGES-1].c_p;
    assign ovf       = ovf_p;
endmodule

// File: tb/tb_param_pipe_adder.sv
// Directed and reference-model checks of param_pipe_adder at four N/STAGES settings.
module tb_param_pipe_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic iv = 1'b0, ir, ov, ordy = 1'b1, cin = 1'b0, sub = 1'b0, cout, ovf;
    logic [31:0] a = '0, b = '0, sum;
    logic iv2 = 1'b0, ir2, ov2, ordy2 = 1'b1, cin2 = 1'b0, sub2 = 1'b0, cout2, ovf2;
    logic [1:0] a2 = '0, b2 = '0, sum2;
    logic iv8 = 1'b0, ir8, ov8, ordy8 = 1'b1, cin8 = 1'b0, sub8 = 1'b0, cout8, ovf8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic iv16 = 1'b0, ir16, ov16, ordy16 = 1'b1, cin16 = 1'b0, sub16 = 1'b0, cout16, ovf16;
    logic [15:0] a16 = '0, b16 = '0, sum16;

    int n_cmp = 0;
    int n_err = 0;
    logic [33:0] q[$];
    logic [33:0] q8[$];
    logic [33:0] q16[$];

    param_pipe_adder #(.N(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov), .out_ready(ordy), .sum(sum), .cout(cout), .ovf(ovf));
    param_pipe_adder #(.N(2), .STAGES(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
        .out_valid(ov2), .out_ready(ordy2), .sum(sum2), .cout(cout2), .ovf(ovf2));
    param_pipe_adder #(.N(8), .STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(ov8), .out_ready(ordy8), .sum(sum8), .cout(cout8), .ovf(ovf8));
    param_pipe_adder #(.N(16), .STAGES(8)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(ov16), .out_ready(ordy16), .sum(sum16), .cout(cout16), .ovf(ovf16));

    // Reference result {ovf, cout, sum} for an n-bit operation, sum zero-extended to 32 bits.
    function automatic logic [33:0] model(int n, logic [31:0] x, logic [31:0] y, logic ci, logic sb);
        logic [31:0] mask, bx, s;
        logic [63:0] r;
        logic co, ov_m;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
        bx   = (y ^ {32{sb}}) & mask;
        r    = 64'(x & mask) + 64'(bx) + 64'(ci ^ sb);
        s    = r[31:0] & mask;
        co   = r[n];
        ov_m = (x[n-1] == bx[n-1]) && (s[n-1] != x[n-1]);
        return {ov_m, co, s};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; iv = 1'b0; iv2 = 1'b0; iv8 = 1'b0; iv16 = 1'b0;
        ordy = 1'b1; ordy2 = 1'b1; ordy8 = 1'b1; ordy16 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; iv = 1'b1; ordy = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (ir !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b required=0", ir); end
        n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b required=0", ov); end
        n_cmp++; if ({ovf, cout, sum} !== 34'h0) begin n_err++; $display("FAIL rst_result got=%h required=0", {ovf, cout, sum}); end
        n_cmp++; if ({ov2, ov8, ov16} !== 3'b000) begin n_err++; $display("FAIL rst_small_valid got=%b required=000", {ov2, ov8, ov16}); end
        iv = 1'b0; rst = 1'b0;
        #1;
        n_cmp++; if (ir !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got=%b required=1", ir); end
    endtask

    task automatic test_add();
        logic [31:0] va[2];
        logic [33:0] ve[2];
        logic exp_ov;
        va = '{32'hFFFF_FFFF, 32'h7FFF_FFFF};
        ve = '{{1'b0, 1'b1, 32'h0000_0000}, {1'b1, 1'b0, 32'h8000_0000}};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            iv = (c < 2); cin = 1'b0; sub = 1'b0; b = 32'd1;
            if (c < 2) a = va[c];
            #1;
            exp_ov = (c >= 4 && c < 6);
            n_cmp++; if (ov !== exp_ov) begin n_err++; $display("FAIL add_valid c=%0d got=%b required=%b", c, ov, exp_ov); end
            if (exp_ov) begin
                n_cmp++;
                if ({ovf, cout, sum} !== ve[c-4]) begin n_err++; $display("FAIL add_result c=%0d got=%h required=%h", c, {ovf, cout, sum}, ve[c-4]); end
            end
        end
    endtask

    task automatic test_sub();
        logic [31:0] va[3], vb[3];
        logic        vc[3];
        logic [33:0] ve[3];
        logic exp_ov;
        va = '{32'd5, 32'h8000_0000, 32'd9};
        vb = '{32'd7, 32'd1, 32'd4};
        vc = '{1'b0, 1'b0, 1'b1};
        ve = '{{1'b0, 1'b0, 32'hFFFF_FFFE}, {1'b1, 1'b1, 32'h7FFF_FFFF}, {1'b0, 1'b1, 32'd4}};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            iv = (c < 3); sub = 1'b1;
            if (c < 3) begin a = va[c]; b = vb[c]; cin = vc[c]; end
            #1;
            exp_ov = (c >= 4 && c < 7);
            n_cmp++; if (ov !== exp_ov) begin n_err++; $display("FAIL sub_valid c=%0d got=%b required=%b", c, ov, exp_ov); end
            if (exp_ov) begin
                n_cmp++;
                if ({ovf, cout, sum} !== ve[c-4]) begin n_err++; $display("FAIL sub_result c=%0d got=%h required=%h", c, {ovf, cout, sum}, ve[c-4]); end
            end
        end
        sub = 1'b0; cin = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc = 0, got = 0, first_acc = -1, first_ov = -1, last_ov = -1;
        logic [33:0] e;
        q.delete();
        ordy = 1'b1;
        for (int c = 0; c < 2100 && got < 2000; c++) begin
            @(negedge clk);
            iv = (acc < 2000);
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            #1;
            if (ov) begin
                if (first_ov < 0) first_ov = c;
                last_ov = c; got++;
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL stream_extra got=%h required=none", {ovf, cout, sum}); end
                else begin
                    e = q.pop_front();
                    if ({ovf, cout, sum} !== e) begin n_err++; $display("FAIL stream_result n=%0d got=%h required=%h", got, {ovf, cout, sum}, e); end
                end
            end
            if (iv && ir) begin
                if (first_acc < 0) first_acc = c;
                q.push_back(model(32, a, b, cin, sub));
                acc++;
            end
        end
        iv = 1'b0;
        n_cmp++; if (got != 2000) begin n_err++; $display("FAIL stream_count got=%0d required=2000", got); end
        n_cmp++; if (first_ov - first_acc != 4) begin n_err++; $display("FAIL stream_latency got=%0d required=4", first_ov - first_acc); end
        n_cmp++; if (last_ov - first_ov != 1999) begin n_err++; $display("FAIL stream_rate got=%0d required=1999", last_ov - first_ov); end
    endtask

    task automatic test_backpressure();
        int acc = 0, got = 0;
        logic [33:0] e, prev;
        logic prev_hold = 1'b0;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            iv = (c < 4); a = 32'(100 + c); b = 32'(c); cin = 1'b0; sub = 1'b0;
            ordy = (c >= 14);
            #1;
            if (c >= 4 && c < 14) begin
                n_cmp++; if (ir !== 1'b0) begin n_err++; $display("FAIL bp_in_ready c=%0d got=%b required=0", c, ir); end
                n_cmp++;
                if ({ov, ovf, cout, sum} !== {3'b100, 32'd100}) begin
                    n_err++; $display("FAIL bp_hold c=%0d got=%h required=%h", c, {ov, ovf, cout, sum}, {3'b100, 32'd100});
                end
            end else if (c >= 14 && c < 18) begin
                n_cmp++;
                if ({ov, ovf, cout, sum} !== {3'b100, 32'(100 + 2 * (c - 14))}) begin
                    n_err++; $display("FAIL bp_drain c=%0d got=%h required=%h", c, {ov, ovf, cout, sum}, {3'b100, 32'(100 + 2 * (c - 14))});
                end
            end else begin
                n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL bp_empty c=%0d got=%b required=0", c, ov); end
            end
        end
        q.delete();
        for (int c = 0; c < 4000 && got < 500; c++) begin
            @(negedge clk);
            iv = (acc < 500) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 1) == 1);
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            #1;
            if (prev_hold) begin
                n_cmp++;
                if ({ov, ovf, cout, sum} !== {1'b1, prev}) begin n_err++; $display("FAIL bpr_hold c=%0d got=%h required=%h", c, {ov, ovf, cout, sum}, {1'b1, prev}); end
            end
            prev_hold = ov && !ordy;
            prev = {ovf, cout, sum};
            if (ov && ordy) begin
                got++; n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL bpr_extra got=%h required=none", {ovf, cout, sum}); end
                else begin
                    e = q.pop_front();
                    if ({ovf, cout, sum} !== e) begin n_err++; $display("FAIL bpr_result n=%0d got=%h required=%h", got, {ovf, cout, sum}, e); end
                end
            end
            if (iv && ir) begin q.push_back(model(32, a, b, cin, sub)); acc++; end
        end
        iv = 1'b0; ordy = 1'b1;
        n_cmp++; if (got != 500 || q.size() != 0) begin n_err++; $display("FAIL bpr_count got=%0d left=%0d required=500/0", got, q.size()); end
    endtask

    task automatic test_reset_mid();
        logic exp_ov;
        ordy = 1'b1;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            rst = (c == 3);
            iv = (c < 4); a = 32'(c + 1); b = 32'd10; cin = 1'b0; sub = 1'b0;
            if (c == 4) begin iv = 1'b1; a = 32'd3; b = 32'd4; end
            #1;
            if (c == 3) begin
                n_cmp++; if (ir !== 1'b0) begin n_err++; $display("FAIL rmid_ready_in_rst got=%b required=0", ir); end
            end
            if (c == 4) begin
                n_cmp++; if (ir !== 1'b1) begin n_err++; $display("FAIL rmid_ready_after got=%b required=1", ir); end
                n_cmp++; if (sum !== 32'd0) begin n_err++; $display("FAIL rmid_sum_cleared got=%h required=0", sum); end
            end
            exp_ov = (c == 8);
            if (c >= 4) begin
                n_cmp++; if (ov !== exp_ov) begin n_err++; $display("FAIL rmid_valid c=%0d got=%b required=%b", c, ov, exp_ov); end
            end
            if (exp_ov) begin
                n_cmp++; if ({ovf, cout, sum} !== {2'b00, 32'd7}) begin n_err++; $display("FAIL rmid_result got=%h required=%h", {ovf, cout, sum}, {2'b00, 32'd7}); end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_exhaustive_n2();
        logic [33:0] e, e_prev = '0;
        logic [5:0] v;
        ordy2 = 1'b1;
        for (int i = 0; i < 66; i++) begin
            @(negedge clk);
            v = 6'(i);
            iv2 = (i < 64);
            {a2, b2, cin2, sub2} = v;
            e = model(2, 32'(a2), 32'(b2), cin2, sub2);
            #1;
            n_cmp++;
            if (ov2 !== (i > 0 && i < 65)) begin n_err++; $display("FAIL n2_valid i=%0d got=%b required=%b", i, ov2, (i > 0 && i < 65)); end
            if (i > 0 && i < 65) begin
                n_cmp++;
                if ({ovf2, cout2, sum2} !== {e_prev[33:32], e_prev[1:0]}) begin
                    n_err++; $display("FAIL n2_result i=%0d got=%b required=%b", i - 1, {ovf2, cout2, sum2}, {e_prev[33:32], e_prev[1:0]});
                end
            end
            e_prev = e;
        end
        iv2 = 1'b0;
    endtask

    task automatic test_small_random();
        int acc8 = 0, got8 = 0, acc16 = 0, got16 = 0;
        logic [33:0] e;
        q8.delete(); q16.delete();
        for (int c = 0; c < 6000 && (got8 < 500 || got16 < 500); c++) begin
            @(negedge clk);
            iv8 = (acc8 < 500) && ($urandom_range(0, 3) != 0);
            iv16 = (acc16 < 500) && ($urandom_range(0, 3) != 0);
            ordy8 = ($urandom_range(0, 3) != 0); ordy16 = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom_range(0, 1)); sub16 = 1'($urandom_range(0, 1));
            #1;
            if (ov8 && ordy8) begin
                got8++; n_cmp++;
                if (q8.size() == 0) begin n_err++; $display("FAIL n8_extra got=%h required=none", {ovf8, cout8, sum8}); end
                else begin
                    e = q8.pop_front();
                    if ({ovf8, cout8, sum8} !== {e[33:32], e[7:0]}) begin n_err++; $display("FAIL n8_result n=%0d got=%h required=%h", got8, {ovf8, cout8, sum8}, {e[33:32], e[7:0]}); end
                end
            end
            if (ov16 && ordy16) begin
                got16++; n_cmp++;
                if (q16.size() == 0) begin n_err++; $display("FAIL n16_extra got=%h required=none", {ovf16, cout16, sum16}); end
                else begin
                    e = q16.pop_front();
                    if ({ovf16, cout16, sum16} !== {e[33:32], e[15:0]}) begin n_err++; $display("FAIL n16_result n=%0d got=%h required=%h", got16, {ovf16, cout16, sum16}, {e[33:32], e[15:0]}); end
                end
            end
            if (iv8 && ir8) begin q8.push_back(model(8, 32'(a8), 32'(b8), cin8, sub8)); acc8++; end
            if (iv16 && ir16) begin q16.push_back(model(16, 32'(a16), 32'(b16), cin16, sub16)); acc16++; end
        end
        iv8 = 1'b0; iv16 = 1'b0;
        n_cmp++; if (got8 != 500) begin n_err++; $display("FAIL n8_count got=%0d required=500", got8); end
        n_cmp++; if (got16 != 500) begin n_err++; $display("FAIL n16_count got=%0d required=500", got16); end
    endtask

    initial begin
        test_reset();
        apply_reset();
        test_add();
        apply_reset();
        test_sub();
        apply_reset();
        test_back_to_back();
        apply_reset();
        test_backpressure();
        apply_reset();
        test_reset_mid();
        apply_reset();
        test_exhaustive_n2();
        apply_reset();
        test_small_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time=%0t required_below=1000000", $time);
        $fatal(1, "simulation time limit reached");
    end
endmodule
